spm_ctrl: RTL and testbench

Scratchpad-memory responder: the memory-side end of the SPM bus driven by the MEM stage. It also serves a read-only instruction-fetch port. Both ports share one single-ported word array. Writes are posted into a 2-entry write buffer and drained into the array when the array port is idle; reads forward data from the buffer. The block sits between the pipeline (IF/MEM stages) and the SPM storage, and reports per-port busy to the pipeline controller.

---
 rtl/spm_ctrl_pkg.sv | 24 ++
 rtl/spm_wbuf.sv | 89 ++++++++
 rtl/spm_ctrl.sv | 116 +++++++++++
 tb/tb_spm_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the scratchpad-memory responder: bus widths,
// the read/write encoding, default geometry and the array-port grant type.
package spm_ctrl_pkg;

    localparam int WORD_DATA_W     = 32;
    localparam int WORD_ADDR_W     = 30;

    localparam logic READ          = 1'b1;
    localparam logic WRITE         = 1'b0;

    localparam int SPM_ADDR_W_DFLT = 12;
    localparam int SPM_DEPTH_DFLT  = 4096;

    typedef logic [WORD_DATA_W-1:0] word_data_t;

    // Owner of the single array port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_MEM,
        GNT_IF,
        GNT_DRAIN
    } arr_gnt_e;

endpackage

// File: rtl/spm_wbuf.sv
// Two-entry in-order write buffer with push/pop, an occupancy count, the head
// entry exposed for draining, and two independent forwarding lookup ports.
module spm_wbuf
    import spm_ctrl_pkg::*;
#(
    parameter int ADDR_W = SPM_ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  word_data_t        push_data,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [ADDR_W-1:0] head_addr,
    output word_data_t        head_data,
    input  logic [ADDR_W-1:0] fwd0_addr,
    output logic              fwd0_hit,
    output word_data_t        fwd0_data,
    input  logic [ADDR_W-1:0] fwd1_addr,
    output logic              fwd1_hit,
    output word_data_t        fwd1_data
);

    logic [ADDR_W-1:0] ent_addr [2];
    word_data_t        ent_data [2];
    logic [1:0]        ent_valid;
    logic              head;
    logic              tail;
    logic              young;

    // The slot opposite the head is the newer one whenever it is valid.
    assign young     = ~head;
    assign head_addr = ent_addr[head];
    assign head_data = ent_data[head];

    // Control state: pointers, valid bits and count.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 2'd0;
            ent_valid <= 2'b00;
            head      <= 1'b0;
            tail      <= 1'b0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= ~head;
            end
            // When full, tail == head: the push must win over the pop's clear.
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= ~tail;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload, written at the tail on push.
    // NOTE: payload storage has no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= push_addr;
            ent_data[tail] <= push_data;
        end
    end

    // Youngest matching valid entry wins; returns {hit, data}.
    function automatic logic [WORD_DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        lookup = '0;
        if (ent_valid[young] && (ent_addr[young] == a)) begin
            lookup = {1'b1, ent_data[young]};
        end else if (ent_valid[head] && (ent_addr[head] == a)) begin
            lookup = {1'b1, ent_data[head]};
        end
    endfunction

    // Forwarding lookups for the MEM and IF read ports.
    // NOTE: every output of a combinational block is assigned on every path.
    always_comb begin
        {fwd0_hit, fwd0_data} = lookup(fwd0_addr);
        {fwd1_hit, fwd1_data} = lookup(fwd1_addr);
    end

endmodule

// File: rtl/spm_ctrl.sv
// Scratchpad-memory responder: arbitrates the single array port between the
// MEM read, the IF read and write-buffer drains, and muxes read data from the
// write buffer (forwarding) or the array.
module spm_ctrl
    import spm_ctrl_pkg::*;
#(
    parameter int SPM_ADDR_W = SPM_ADDR_W_DFLT,
    parameter int SPM_DEPTH  = SPM_DEPTH_DFLT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] if_spm_addr,
    input  logic                   if_spm_as_,
    output logic [WORD_DATA_W-1:0] if_spm_rd_data,
    output logic                   if_spm_busy,
    input  logic [WORD_ADDR_W-1:0] spm_addr,
    input  logic                   spm_as_,
    input  logic                   spm_rw,
    input  logic [WORD_DATA_W-1:0] spm_wr_data,
    output logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic                   spm_busy
);

    logic                  mem_rd;
    logic                  mem_wr;
    logic                  if_rd;
    logic                  wr_acc;
    logic                  drain_en;
    logic [1:0]            cnt;
    arr_gnt_e              gnt;
    logic [SPM_ADDR_W-1:0] mem_idx;
    logic [SPM_ADDR_W-1:0] if_idx;
    logic [SPM_ADDR_W-1:0] head_addr;
    logic [SPM_ADDR_W-1:0] arr_idx;
    word_data_t            head_data;
    word_data_t            arr_q;
    logic                  mem_hit;
    word_data_t            mem_fwd;
    logic                  if_hit;
    word_data_t            if_fwd;
    logic                  unused_addr_hi;

    word_data_t            mem [SPM_DEPTH];

    assign mem_rd  = ~spm_as_ & (spm_rw == READ);
    assign mem_wr  = ~spm_as_ & (spm_rw == WRITE);
    assign if_rd   = ~if_spm_as_;

    // The array is indexed by the low word-address bits; upper bits alias.
    assign mem_idx = spm_addr[SPM_ADDR_W-1:0];
    assign if_idx  = if_spm_addr[SPM_ADDR_W-1:0];
    assign unused_addr_hi = ^{spm_addr[WORD_ADDR_W-1:SPM_ADDR_W],
                              if_spm_addr[WORD_ADDR_W-1:SPM_ADDR_W]};

    // Array port grant: MEM read, then IF read, then a pending drain.
    always_comb begin
        gnt = GNT_NONE;
        if (mem_rd) begin
            gnt = GNT_MEM;
        end else if (if_rd) begin
            gnt = GNT_IF;
        end else if (cnt != 2'd0) begin
            gnt = GNT_DRAIN;
        end
    end

    assign drain_en    = (gnt == GNT_DRAIN);
    assign wr_acc      = mem_wr & ((cnt < 2'd2) | drain_en);
    assign spm_busy    = mem_wr & ~wr_acc;
    assign if_spm_busy = if_rd & mem_rd;

    spm_wbuf #(
        .ADDR_W (SPM_ADDR_W)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_acc),
        .push_addr (mem_idx),
        .push_data (spm_wr_data),
        .pop       (drain_en),
        .cnt       (cnt),
        .head_addr (head_addr),
        .head_data (head_data),
        .fwd0_addr (mem_idx),
        .fwd0_hit  (mem_hit),
        .fwd0_data (mem_fwd),
        .fwd1_addr (if_idx),
        .fwd1_hit  (if_hit),
        .fwd1_data (if_fwd)
    );

    // One address serves both the read and the drain write of the array.
    assign arr_idx = (gnt == GNT_MEM) ? mem_idx :
                     (gnt == GNT_IF)  ? if_idx  : head_addr;
    assign arr_q   = mem[arr_idx];

    // Drain the buffer head into the array on the same edge it is popped.
    always_ff @(posedge clk) begin
        if (drain_en) begin
            mem[arr_idx] <= head_data;
        end
    end

    // Read data: buffer forwarding over array contents, zero when not served.
    always_comb begin
        spm_rd_data    = '0;
        if_spm_rd_data = '0;
        if (gnt == GNT_MEM) begin
            spm_rd_data = mem_hit ? mem_fwd : arr_q;
        end
        if (gnt == GNT_IF) begin
            if_spm_rd_data = if_hit ? if_fwd : arr_q;
        end
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed self-checking bench for spm_ctrl: forwarding, stalls, drains,
// port arbitration, reset discard and address aliasing.
module tb_spm_ctrl;

    logic        clk;
    logic        reset;
    logic [29:0] if_spm_addr;
    logic        if_spm_as_;
    logic [31:0] if_spm_rd_data;
    logic        if_spm_busy;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
    logic        spm_busy;

    int errors = 0;
    int checks = 0;

    spm_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_spm_addr    (if_spm_addr),
        .if_spm_as_     (if_spm_as_),
        .if_spm_rd_data (if_spm_rd_data),
        .if_spm_busy    (if_spm_busy),
        .spm_addr       (spm_addr),
        .spm_as_        (spm_as_),
        .spm_rw         (spm_rw),
        .spm_wr_data    (spm_wr_data),
        .spm_rd_data    (spm_rd_data),
        .spm_busy       (spm_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
        check(tag, {30'd0, dut.u_wbuf.cnt}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [29:0] a, input logic [31:0] d);
        spm_as_     = 1'b0;
        spm_rw      = 1'b0;
        spm_addr    = a;
        spm_wr_data = d;
    endtask

    task automatic mem_read(input logic [29:0] a);
        spm_as_     = 1'b0;
        spm_rw      = 1'b1;
        spm_addr    = a;
        spm_wr_data = 32'h0;
    endtask

    task automatic mem_idle();
        spm_as_  = 1'b1;
        spm_rw   = 1'b1;
        spm_addr = 30'h0;
    endtask

    task automatic if_req(input logic [29:0] a);
        if_spm_as_  = 1'b0;
        if_spm_addr = a;
    endtask

    task automatic if_idle();
        if_spm_as_  = 1'b1;
        if_spm_addr = 30'h0;
    endtask

    initial begin
        reset       = 1'b1;
        spm_wr_data = 32'h0;
        mem_idle();
        if_idle();
        #1;
        check("rst_spm_rd_data", spm_rd_data, 32'h0);
        check("rst_if_rd_data", if_spm_rd_data, 32'h0);
        check("rst_spm_busy", {31'd0, spm_busy}, 32'h0);
        check("rst_if_busy", {31'd0, if_spm_busy}, 32'h0);
        check_cnt("rst_cnt", 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Basic posted write, then forwarded read next cycle.
        mem_write(30'h10, 32'hDEADBEEF);
        #1;
        check("wr1_busy", {31'd0, spm_busy}, 32'h0);
        check("wr1_no_rd_data", spm_rd_data, 32'h0);
        tick();
        mem_read(30'h10);
        #1;
        check("rd1_fwd", spm_rd_data, 32'hDEADBEEF);
        tick();
        mem_idle();
        tick();
        check_cnt("wr1_drained", 32'd0);
        if_req(30'h10);
        #1;
        check("rd1_if_array", if_spm_rd_data, 32'hDEADBEEF);
        tick();

        // IF strobe held: buffer fills, third write stalls until IF releases.
        if_req(30'h20);
        mem_write(30'h20, 32'h1);
        #1;
        check("stall_w1_busy", {31'd0, spm_busy}, 32'h0);
        tick();
        mem_write(30'h20, 32'h2);
        #1;
        check("stall_w2_busy", {31'd0, spm_busy}, 32'h0);
        tick();
        mem_write(30'h20, 32'h3);
        #1;
        check("stall_w3_busy", {31'd0, spm_busy}, 32'h1);
        check("stall_if_young", if_spm_rd_data, 32'h2);
        tick();
        check("stall_w3_retry_busy", {31'd0, spm_busy}, 32'h1);
        check_cnt("stall_cnt_full", 32'd2);
        if_idle();
        #1;
        check("stall_w3_release", {31'd0, spm_busy}, 32'h0);
        tick();
        mem_read(30'h20);
        #1;
        check("stall_mem_rd_young", spm_rd_data, 32'h3);
        tick();
        mem_idle();
        if_req(30'h20);
        #1;
        check("stall_if_rd_young", if_spm_rd_data, 32'h3);
        check("stall_if_not_busy", {31'd0, if_spm_busy}, 32'h0);
        tick();
        if_idle();
        tick();
        tick();
        check_cnt("stall_drained", 32'd0);
        mem_read(30'h20);
        #1;
        check("stall_array_last", spm_rd_data, 32'h3);
        tick();

        // Fill the buffer with distinct addresses, then let it drain.
        if_req(30'h20);
        mem_write(30'h21, 32'hA);
        tick();
        mem_write(30'h22, 32'hB);
        tick();
        mem_idle();
        if_idle();
        #1;
        check_cnt("drain_cnt2", 32'd2);
        tick();
        check_cnt("drain_cnt1", 32'd1);
        tick();
        check_cnt("drain_cnt0", 32'd0);

        // Simultaneous MEM and IF reads: IF stalls, then completes.
        mem_read(30'h21);
        if_req(30'h22);
        #1;
        check("both_if_busy", {31'd0, if_spm_busy}, 32'h1);
        check("both_if_data", if_spm_rd_data, 32'h0);
        check("both_mem_data", spm_rd_data, 32'hA);
        check("both_mem_busy", {31'd0, spm_busy}, 32'h0);
        tick();
        mem_idle();
        #1;
        check("if_retry_busy", {31'd0, if_spm_busy}, 32'h0);
        check("if_retry_data", if_spm_rd_data, 32'hB);
        tick();
        if_idle();

        // Reset while a buffered write is pending discards it.
        mem_write(30'h30, 32'h11);
        tick();
        mem_idle();
        tick();
        mem_write(30'h30, 32'h55);
        tick();
        mem_idle();
        reset = 1'b1;
        #1;
        check_cnt("rst_mid_cnt", 32'd0);
        tick();
        reset = 1'b0;
        mem_read(30'h30);
        #1;
        check("rst_mid_old_data", spm_rd_data, 32'h11);
        tick();

        // Upper address bits are ignored.
        mem_write(30'h1010, 32'h5);
        tick();
        mem_read(30'h0010);
        #1;
        check("alias_fwd", spm_rd_data, 32'h5);
        tick();
        mem_idle();
        tick();
        if_req(30'h0010);
        #1;
        check("alias_array", if_spm_rd_data, 32'h5);
        tick();
        if_idle();

        // Back-to-back writes without IF traffic never stall.
        for (int i = 0; i < 4; i++) begin
            mem_write(30'h40 + 30'(i), 32'h100 + 32'(i));
            #1;
            check($sformatf("stream_busy_%0d", i), {31'd0, spm_busy}, 32'h0);
            tick();
        end
        mem_idle();
        #1;
        check_cnt("stream_cnt", 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_read(30'h40 + 30'(i));
            #1;
            check($sformatf("stream_rd_%0d", i), spm_rd_data, 32'h100 + 32'(i));
            tick();
        end

        mem_idle();
        if_idle();
        #1;
        check("idle_spm_rd_data", spm_rd_data, 32'h0);
        check("idle_if_rd_data", if_spm_rd_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
